// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready request in, held result out; shifts iterate one bit per cycle.
// Define ALU_SEQ_FAST_SHIFT_EN to use a single-cycle barrel shifter instead (same results, latency 1).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] ALU_ADD              = 4'd0;
  localparam logic [3:0] ALU_SUB              = 4'd1;
  localparam logic [3:0] ALU_AND              = 4'd2;
  localparam logic [3:0] ALU_OR               = 4'd3;
  localparam logic [3:0] ALU_XOR              = 4'd4;
  localparam logic [3:0] ALU_SHIFTL           = 4'd5;
  localparam logic [3:0] ALU_SHIFTR           = 4'd6;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd7;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd8;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd9;
  localparam logic [3:0] ALU_COPY_B           = 4'd10;
  localparam logic [3:0] ALU_NONE             = 4'd11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             out_valid_q;
  logic [4:0]       cnt_q;
  logic [3:0]       op_q;

  logic [WIDTH-1:0] load_d;
  logic [WIDTH-1:0] step_d;
  logic [4:0]       shamt;
  logic             is_shift;
  logic             go_shift;

  assign shamt    = src_b[4:0];
  assign is_shift = (alu_control == ALU_SHIFTL) || (alu_control == ALU_SHIFTR) ||
                    (alu_control == ALU_SHIFTR_ARITH);
`ifdef ALU_SEQ_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = is_shift && (shamt != 5'd0);
`endif

  // Value loaded at acceptance; in the iterative build a shift only lands here when shamt is 0
  always_comb begin
    load_d = '0;
    case (alu_control)
      ALU_ADD:              load_d = src_a + src_b;
      ALU_SUB:              load_d = src_a - src_b;
      ALU_AND:              load_d = src_a & src_b;
      ALU_OR:               load_d = src_a | src_b;
      ALU_XOR:              load_d = src_a ^ src_b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
      ALU_SHIFTL:           load_d = src_a << shamt;
      ALU_SHIFTR:           load_d = src_a >> shamt;
      ALU_SHIFTR_ARITH:     load_d = WIDTH'($signed(src_a) >>> shamt);
`else
      ALU_SHIFTL,
      ALU_SHIFTR,
      ALU_SHIFTR_ARITH:     load_d = src_a;
`endif
      ALU_LESS_THAN_SIGNED: load_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_LESS_THAN:        load_d = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      ALU_COPY_B:           load_d = src_b;
      ALU_NONE:             load_d = '0;
      default:              load_d = '0;
    endcase
  end

  always_comb begin
    step_d = result_q;
    case (op_q)
      ALU_SHIFTL:       step_d = {result_q[WIDTH-2:0], 1'b0};
      ALU_SHIFTR:       step_d = {1'b0, result_q[WIDTH-1:1]};
      ALU_SHIFTR_ARITH: step_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default:          step_d = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      op_q        <= ALU_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (go_shift) begin
              result_q <= src_a;
              zero_q   <= (src_a == '0);
              cnt_q    <= shamt;
              op_q     <= alu_control;
              state_q  <= SHIFT;
            end else begin
              result_q    <= load_d;
              zero_q      <= (load_d == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        SHIFT: begin
          result_q <= step_d;
          zero_q   <= (step_d == '0);
          cnt_q    <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Consuming lands in IDLE, so a new request cannot overlap the hand-off cycle
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: table of ops plus hand-written backpressure and reset sequences.
module tb_alu_seq;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SHL = 4'd5, SHR = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
  localparam logic [3:0] CPYB = 4'd10, NONE = 4'd11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.z = z;
    vq.push_back(v);
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1;
`else
    if ((op == SHL || op == SHR || op == SRA) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Entered and left at a negedge with the DUT idle; holds out_ready low for `hold` DONE cycles
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input logic z, input int hold);
    int lat;
    logic [31:0] first_r;
    chk({nm, " in_ready before"}, {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_control = ~op; src_a = ~a; src_b = b ^ 32'h5A5A_5A5A;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      chk({nm, " busy while working"}, {31'b0, busy}, 32'h1);
      if (lat > 60) break;
    end
    chk({nm, " latency"}, lat, exp_lat(op, b));
    chk({nm, " result"}, result, r);
    chk({nm, " zero"}, {31'b0, zero}, {31'b0, z});
    first_r = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; alu_control = ADD; src_a = 32'h1111; src_b = 32'h2222;
      @(negedge clk);
      chk({nm, " held out_valid"}, {31'b0, out_valid}, 32'h1);
      chk({nm, " held result"}, result, first_r);
      chk({nm, " held zero"}, {31'b0, zero}, {31'b0, z});
      chk({nm, " held in_ready"}, {31'b0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " out_valid after consume"}, {31'b0, out_valid}, 32'h0);
    chk({nm, " busy after consume"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    addv(ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
    addv(ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
    addv(SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
    addv(SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    addv(AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    addv(OR_,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0);
    addv(XOR_, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0);
    addv(SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    addv(SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
    addv(SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    addv(SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    addv(CPYB, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    addv(NONE, 32'h00000123, 32'h00000456, 32'h00000000, 1'b1);
    addv(4'hF, 32'h00000123, 32'h00000456, 32'h00000000, 1'b1);
    addv(SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
    addv(SRA,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0);
    addv(SRA,  32'h7FFFFFFF, 32'h00000003, 32'h0FFFFFFF, 1'b0);
    addv(SHL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0);
    addv(SHL,  32'h0000FFFF, 32'h00000010, 32'hFFFF0000, 1'b0);
    addv(SHL,  32'h00000001, 32'h00000008, 32'h00000100, 1'b0);
    addv(SHR,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0);
    addv(SHR,  32'hF0000000, 32'h00000024, 32'h0F000000, 1'b0);
    addv(SHR,  32'h00000001, 32'h00000001, 32'h00000000, 1'b1);

    // Reset state, with out_ready high to show it is ignored outside DONE
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("in_ready during rst", {31'b0, in_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset result", result, 32'h0);
    chk("reset zero", {31'b0, zero}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    out_ready = 1'b0;

    for (int i = 0; i < vq.size(); i++)
      run_op($sformatf("vec%0d", i), vq[i].op, vq[i].a, vq[i].b, vq[i].r, vq[i].z, 0);

    // Backpressure for 3 cycles, then an immediate follow-up request
    run_op("bp add", ADD, 32'h2, 32'h3, 32'h5, 1'b0, 3);
    run_op("bp follow", SUB, 32'h9, 32'h9, 32'h0, 1'b1, 0);
`ifndef ALU_SEQ_FAST_SHIFT_EN
    run_op("bp shift", SHR, 32'h00000100, 32'h8, 32'h1, 1'b0, 3);
`endif

    // Reset in the middle of a long shift
    chk("midrst in_ready", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; alu_control = SHL; src_a = 32'h1; src_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
`ifndef ALU_SEQ_FAST_SHIFT_EN
    chk("midrst busy before", {31'b0, busy}, 32'h1);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("midrst in_ready during rst", {31'b0, in_ready}, 32'h0);
    rst = 1'b0;
    chk("midrst busy", {31'b0, busy}, 32'h0);
    chk("midrst out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst result", result, 32'h0);
    chk("midrst zero", {31'b0, zero}, 32'h0);
    begin
      logic late;
      late = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) late = 1'b1;
      end
      chk("midrst no late out_valid", {31'b0, late}, 32'h0);
    end
    run_op("after rst", ADD, 32'h10, 32'h20, 32'h30, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width in bits; only 32 supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: alu_control  input  4  operation code, define.v encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHIFTL, ALU_SHIFTR, ALU_SHIFTR_ARITH, ALU_LESS_THAN_SIGNED, ALU_LESS_THAN, ALU_COPY_B, ALU_NONE).
REQ-007 SHALL have port: src_a  input  WIDTH  operand A.
REQ-008 SHALL have port: src_b  input  WIDTH  operand B; src_b[4:0] is shift amount.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  WIDTH  registered result.
REQ-012 SHALL have port: zero  output  1  registered, 1 when result == 0.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; a request is accepted on a cycle with in_valid && in_ready; operands and alu_control are captured at acceptance, later input changes ignored.
REQ-016 SHALL, for non-shift ops, load result at acceptance and enter DONE; out_valid asserts the next cycle (latency 1).
REQ-017 SHALL compute ADD/SUB modulo 2^32 (carry/borrow discarded); AND/OR/XOR bitwise; LESS_THAN_SIGNED and LESS_THAN yield 32'h1 or 32'h0 (two's-complement signed / unsigned compare); COPY_B yields src_b; ALU_NONE and any undefined code yield 32'h0.
REQ-018 SHALL, for shift ops with shamt == 0, load result = src_a and enter DONE (latency 1).
REQ-019 SHALL, for shift ops with shamt != 0, load working register = src_a and counter = shamt, enter SHIFT; each SHIFT cycle shifts one bit (SHIFTL zero-fill, SHIFTR zero-fill, SHIFTR_ARITH replicates bit 31) and decrements counter; on the cycle counter goes 1 -> 0, enter DONE (latency shamt + 1 cycles).
REQ-020 SHALL hold out_valid, result and zero stable in DONE until out_valid && out_ready; on that cycle return to IDLE, out_valid deasserts next cycle.
REQ-021 SHALL not accept a new request in the same cycle a result is consumed (one-cycle IDLE bubble between operations).
REQ-022 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-023 SHALL update zero in the same cycle result is loaded.

Reset
REQ-024 SHALL, with rst high at a rising edge, force state IDLE, out_valid 0, result 32'h0, zero 0, counter 0, busy 0 next cycle, regardless of state.
REQ-025 SHALL abandon any in-progress shift or pending result on reset; no out_valid is produced for it.
REQ-026 SHALL hold in_ready 0 during the cycle rst is high.

Configuration
REQ-027 SHALL, when macro ALU_SEQ_FAST_SHIFT_EN is defined, perform all shifts in one cycle (barrel shifter, latency 1, SHIFT state unreachable).
REQ-028 SHALL, when ALU_SEQ_FAST_SHIFT_EN is undefined, use the iterative shifter of REQ-019; results identical in both builds, only latency differs.

Verification
REQ-029 SHALL cover: ADD src_a=32'h7FFFFFFF, src_b=1, out_ready=1 -> out_valid one cycle after accept, result 32'h80000000, zero 0.
REQ-030 SHALL cover: SUB src_a=5, src_b=5 -> result 0, zero 1; LESS_THAN_SIGNED 32'hFFFFFFFF vs 1 -> 1; LESS_THAN same operands -> 0.
REQ-031 SHALL cover (iterative build): SHIFTR_ARITH src_a=32'h80000000, src_b=4 -> out_valid 5 cycles after accept, result 32'hF8000000, busy high throughout; shamt=0 -> result src_a at latency 1.
REQ-032 SHALL cover: out_ready held 0 for 3 cycles in DONE -> result/zero stable, in_ready 0; out_ready 1 -> IDLE, next request accepted one cycle later.
REQ-033 SHALL cover: rst asserted in SHIFT mid-operation (SHIFTL src_b=20) -> next cycle IDLE, out_valid 0, result 0, no late out_valid.
REQ-034 SHALL cover: undefined alu_control 4'hF and ALU_NONE -> result 0, zero 1; COPY_B src_b=32'hDEADBEEF -> result 32'hDEADBEEF.
